// File: rtl/recip_pkg.sv
// Shared types and constants for the reciprocal round/pack wrapper.
package recip_pkg;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    NORMAL = 3'd1,
    INF    = 3'd2,
    QNAN   = 3'd3,
    SNAN   = 3'd4
  } cls_e;

  // Bit positions inside the 4-bit status word {invalid, div_by_zero, underflow, inexact}
  localparam int unsigned ST_W           = 4;
  localparam int unsigned ST_INVALID     = 3;
  localparam int unsigned ST_DIV_BY_ZERO = 2;
  localparam int unsigned ST_UNDERFLOW   = 1;
  localparam int unsigned ST_INEXACT     = 0;

  // Exponent field of a delay-line entry is sized for the widest supported format
  localparam int unsigned EXP_W_MAX = 15;

  function automatic int unsigned calc_bias(input int unsigned exp_width);
    return (32'd1 << (exp_width - 32'd1)) - 32'd1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [EXP_W_MAX-1:0] exp;
    logic                 frac_is_zero;
    cls_e                 cls;
  } dl_entry_t;

endpackage

// File: rtl/recip_round_pack_if.sv
// Operand/result handshake bundle for recip_round_pack.
interface recip_round_pack_if #(
  parameter int unsigned sig_width = 23,
  parameter int unsigned exp_width = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic [sig_width+exp_width:0]   x_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [sig_width+exp_width:0]   z_out;
  logic [3:0]                     status;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, z_out, status
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, z_out, status
  );
endinterface

// File: rtl/recip_round_pack_classify.sv
// Operand classifier: subnormals are treated as zero.
module recip_classify
  import recip_pkg::*;
#(
  parameter int unsigned sig_width = 23,
  parameter int unsigned exp_width = 8
) (
  input  logic [exp_width-1:0] exp_field,
  input  logic [sig_width-1:0] frac,
  output cls_e                 cls,
  output logic                 frac_is_zero
);

  // Decode exponent/fraction into the operand class
  always_comb begin
    frac_is_zero = (frac == '0);
    cls          = NORMAL;
    if (exp_field == '0) begin
      cls = ZERO;
    end else if (&exp_field) begin
      if (frac_is_zero)          cls = INF;
      else if (frac[sig_width-1]) cls = QNAN;
      else                       cls = SNAN;
    end
  end

endmodule

// File: rtl/recip_round_pack.sv
// Front/back-end wrapper around the SRT reciprocal significand engine.
// Optional macro RECIP_FLAGS_EN: when defined, status flags are computed and
// registered; otherwise status is tied to zero.
module recip_round_pack
  import recip_pkg::*;
#(
  parameter int unsigned sig_width   = 23,
  parameter int unsigned exp_width   = 8,
  parameter int unsigned pipe_stages = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  recip_round_pack_if.slave    bus,
  output logic [sig_width:0]   d_out,
  output logic                 sig_enable,
  input  logic [sig_width:0]   quotient,
  input  logic                 guard_bit,
  input  logic                 round_bit,
  input  logic                 sticky_bit
);

  localparam int unsigned         EW       = exp_width + 2;
  localparam int unsigned         BIAS     = calc_bias(exp_width);
  localparam logic [EW-1:0]       TWO_BIAS = EW'(2 * BIAS);
  localparam logic [exp_width-1:0] EXP_ONES = '1;

  logic                         advance;
  logic [exp_width-1:0]         x_exp;
  logic [sig_width-1:0]         x_frac;
  cls_e                         x_cls;
  logic                         x_frac_zero;
  dl_entry_t                    in_e;
  dl_entry_t                    rs;
  logic [exp_width-1:0]         rs_exp;
  logic                         rnd_up;
  logic                         carry;
  logic                         flush;
  logic [sig_width:0]           mant_sum;
  logic [sig_width-1:0]         mant;
  logic [EW-1:0]                e_pre;
  logic [sig_width+exp_width:0] z_nxt;
  logic                         unused_bits;

  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;
  assign sig_enable   = advance;
  assign x_exp        = bus.x_in[sig_width +: exp_width];
  assign x_frac       = bus.x_in[sig_width-1:0];
  assign d_out        = {1'b1, x_frac};
  assign rs_exp       = rs.exp[exp_width-1:0];
  assign unused_bits  = ^{rs.exp, quotient[sig_width]};

  recip_classify #(
    .sig_width (sig_width),
    .exp_width (exp_width)
  ) u_classify (
    .exp_field    (x_exp),
    .frac         (x_frac),
    .cls          (x_cls),
    .frac_is_zero (x_frac_zero)
  );

  // Side-band entry that travels alongside the operand through the engine
  always_comb begin
    in_e              = '0;
    in_e.valid        = bus.in_valid;
    in_e.sign         = bus.x_in[sig_width+exp_width];
    in_e.exp          = EXP_W_MAX'(x_exp);
    in_e.frac_is_zero = x_frac_zero;
    in_e.cls          = x_cls;
  end

  if (pipe_stages == 0) begin : g_no_pipe
    assign rs = in_e;
  end else begin : g_pipe
    dl_entry_t dl [pipe_stages];

    // Delay line matched to the engine depth; frozen while the output stalls
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int unsigned i = 0; i < pipe_stages; i++) dl[i] <= '0;
      end else if (advance) begin
        dl[0] <= in_e;
        for (int unsigned i = 1; i < pipe_stages; i++) dl[i] <= dl[i-1];
      end
    end

    assign rs = dl[pipe_stages-1];
  end

  // RNE increment and biased result exponent for normal operands
  always_comb begin
    rnd_up   = guard_bit & (round_bit | sticky_bit | quotient[0]);
    mant_sum = {1'b0, quotient[sig_width-1:0]} + (sig_width+1)'(rnd_up);
    carry    = mant_sum[sig_width];
    if (rs.frac_is_zero) begin
      // Power of two: exact result, engine bits are irrelevant
      e_pre = TWO_BIAS - EW'(rs_exp);
      mant  = '0;
    end else begin
      e_pre = TWO_BIAS - EW'(rs_exp) - EW'(1) + EW'(carry);
      mant  = mant_sum[sig_width-1:0];
    end
    flush = e_pre[EW-1] | (e_pre == '0);
  end

  // Result packing, including specials and flush-to-zero
  always_comb begin
    z_nxt = '0;
    case (rs.cls)
      ZERO:       z_nxt = {rs.sign, EXP_ONES, sig_width'(0)};
      INF:        z_nxt = {rs.sign, {(exp_width+sig_width){1'b0}}};
      QNAN, SNAN: z_nxt = {1'b0, EXP_ONES, 1'b1, (sig_width-1)'(0)};
      default:    z_nxt = flush ? {rs.sign, {(exp_width+sig_width){1'b0}}}
                                : {rs.sign, e_pre[exp_width-1:0], mant};
    endcase
  end

  // Output register: result and valid advance together
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.z_out     <= '0;
    end else if (advance) begin
      bus.out_valid <= rs.valid;
      bus.z_out     <= z_nxt;
    end
  end

`ifdef RECIP_FLAGS_EN
  logic [ST_W-1:0] st_nxt;

  // Exception flags for the entry in the round stage
  always_comb begin
    st_nxt = '0;
    case (rs.cls)
      ZERO: st_nxt[ST_DIV_BY_ZERO] = 1'b1;
      SNAN: st_nxt[ST_INVALID]     = 1'b1;
      NORMAL: begin
        if (flush) begin
          st_nxt[ST_UNDERFLOW] = 1'b1;
          st_nxt[ST_INEXACT]   = 1'b1;
        end else if (!rs.frac_is_zero) begin
          st_nxt[ST_INEXACT] = guard_bit | round_bit | sticky_bit;
        end
      end
      default: st_nxt = '0;
    endcase
  end

  // Status register shares the output register's enable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      bus.status <= '0;
    else if (advance) bus.status <= st_nxt;
  end
`else
  assign bus.status = '0;
`endif

endmodule

// File: tb/tb_recip_round_pack.sv
`timescale 1ns/1ps
module tb_recip_round_pack;

  localparam int unsigned SW  = 23;
  localparam int unsigned EWD = 8;
`ifdef RECIP_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  typedef struct { logic [31:0] x; logic [31:0] z; logic [3:0] st; } vec_t;
  typedef struct { logic [31:0] z; logic [3:0] st; int cyc; } exp_t;

  logic clk = 1'b0;
  logic resetn0, resetn2;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  recip_round_pack_if #(.sig_width(SW), .exp_width(EWD)) if0 ();
  recip_round_pack_if #(.sig_width(SW), .exp_width(EWD)) if2 ();

  logic [SW:0] d0, d2, qt0, qt2;
  logic        g0, r0, s0, g2, r2, s2, en0, en2;
  logic [26:0] e2a, e2b;

  recip_round_pack #(.sig_width(SW), .exp_width(EWD), .pipe_stages(0)) u0 (
    .clk(clk), .resetn(resetn0), .bus(if0), .d_out(d0), .sig_enable(en0),
    .quotient(qt0), .guard_bit(g0), .round_bit(r0), .sticky_bit(s0));

  recip_round_pack #(.sig_width(SW), .exp_width(EWD), .pipe_stages(2)) u2 (
    .clk(clk), .resetn(resetn2), .bus(if2), .d_out(d2), .sig_enable(en2),
    .quotient(qt2), .guard_bit(g2), .round_bit(r2), .sticky_bit(s2));

  // Engine stand-in: {quotient, g, r, s} per divisor fraction (some entries synthetic)
  function automatic logic [26:0] eng(input logic [23:0] d);
    case (d[22:0])
      23'h400000: return {24'hAAAAAA, 3'b101};  // 2/1.5
      23'h200000: return {24'hCCCCCC, 3'b111};  // 2/1.25
      23'h7FFFFF: return {24'h800000, 3'b101};  // 2/(2-ulp)
      23'h000002: return {24'h800000, 3'b100};  // tie, even lsb
      23'h000003: return {24'h800001, 3'b100};  // tie, odd lsb
      default:    return {24'hFFFFFF, 3'b111};  // all ones: forces carry-out
    endcase
  endfunction

  always_comb {qt0, g0, r0, s0} = eng(d0);

  always @(posedge clk) begin
    if (en2) begin
      e2a <= eng(d2);
      e2b <= e2a;
    end
  end
  assign {qt2, g2, r2, s2} = e2b;

  vec_t vecs [18] = '{
    '{32'h40000000, 32'h3F000000, 4'b0000},
    '{32'h3FC00000, 32'h3F2AAAAB, 4'b0001},
    '{32'h80000000, 32'hFF800000, 4'b0100},
    '{32'h7F800001, 32'h7FC00000, 4'b1000},
    '{32'h7F800000, 32'h00000000, 4'b0000},
    '{32'h7F7FFFFF, 32'h00000000, 4'b0011},
    '{32'hC0400000, 32'hBEAAAAAB, 4'b0001},
    '{32'h3FFFFFFF, 32'h3F000001, 4'b0001},
    '{32'h3FA00000, 32'h3F4CCCCD, 4'b0001},
    '{32'h3F800001, 32'h3F800000, 4'b0001},
    '{32'h3F800002, 32'h3F000000, 4'b0001},
    '{32'h3F800003, 32'h3F000002, 4'b0001},
    '{32'h00000001, 32'h7F800000, 4'b0100},
    '{32'hFF800000, 32'h80000000, 4'b0000},
    '{32'hFFC00001, 32'h7FC00000, 4'b0000},
    '{32'h7F000000, 32'h00000000, 4'b0011},
    '{32'h00800000, 32'h7E800000, 4'b0000},
    '{32'hBF800000, 32'hBF800000, 4'b0000}
  };

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Scoreboard monitors: a result is consumed on a sampled valid&ready
  always @(negedge clk) begin
    exp_t e;
    if (if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u0_unexpected: got z=%08h, required no output", if0.z_out);
      end else begin
        e = q0.pop_front();
        chk("u0_z", if0.z_out, e.z);
        chk("u0_status", 32'(if0.status), 32'(e.st));
        chk("u0_latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if2.out_valid && if2.out_ready) begin
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u2_unexpected: got z=%08h, required no output", if2.z_out);
      end else begin
        e = q2.pop_front();
        chk("u2_z", if2.z_out, e.z);
        chk("u2_status", 32'(if2.status), 32'(e.st));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send0(input vec_t v);
    int   n;
    exp_t e;
    if0.in_valid = 1'b1;
    if0.x_in     = v.x;
    #1;
    n = 0;
    while (!if0.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!if0.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL u0_accept: in_ready 0 after %0d cycles, required 1", n);
    end else begin
      chk("u0_d_out", 32'(d0), 32'({1'b1, v.x[22:0]}));
      e.z = v.z; e.st = v.st & FLAG_MASK; e.cyc = cyc;
      q0.push_back(e);
    end
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
  endtask

  task automatic send2(input vec_t v);
    int   n;
    exp_t e;
    if2.in_valid = 1'b1;
    if2.x_in     = v.x;
    #1;
    n = 0;
    while (!if2.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!if2.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL u2_accept: in_ready 0 after %0d cycles, required 1", n);
    end else begin
      chk("u2_d_out", 32'(d2), 32'({1'b1, v.x[22:0]}));
      e.z = v.z; e.st = v.st & FLAG_MASK; e.cyc = cyc;
      q2.push_back(e);
    end
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    resetn0 = 1'b0; resetn2 = 1'b0;
    if0.in_valid = 1'b0; if0.x_in = '0; if0.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.x_in = '0; if2.out_ready = 1'b1;
    #12;
    chk("rst_u0_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_u0_z", if0.z_out, 32'd0);
    chk("rst_u0_status", 32'(if0.status), 32'd0);
    chk("rst_u0_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_u0_sig_enable", 32'(en0), 32'd1);
    chk("rst_u2_valid", 32'(if2.out_valid), 32'd0);
    chk("rst_u2_z", if2.z_out, 32'd0);
    @(posedge clk); #1;
    resetn0 = 1'b1; resetn2 = 1'b1;

    // Single-cycle engine: back-to-back directed vectors
    foreach (vecs[i]) send0(vecs[i]);

    // Two-stage engine: three in a row, then a downstream stall
    if2.out_ready = 1'b0;
    send2(vecs[0]); send2(vecs[1]); send2(vecs[2]);
    n = 0;
    while (!if2.out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("u2_first_valid", 32'(if2.out_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_sig_enable", 32'(en2), 32'd0);
      chk("stall_in_ready", 32'(if2.in_ready), 32'd0);
      chk("stall_valid", 32'(if2.out_valid), 32'd1);
      chk("stall_z", if2.z_out, q2[0].z);
    end
    @(posedge clk); #1;
    if2.out_ready = 1'b1;
    n = 0;
    while (q2.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end

    // Reset pulse with results in flight
    send2(vecs[6]); send2(vecs[8]); send2(vecs[12]); send2(vecs[7]);
    chk("pre_reset_valid", 32'(if2.out_valid), 32'd1);
    @(posedge clk); #1;
    resetn2 = 1'b0;
    if2.out_ready = 1'b0;
    #1;
    chk("reset_valid", 32'(if2.out_valid), 32'd0);
    chk("reset_z", if2.z_out, 32'd0);
    chk("reset_status", 32'(if2.status), 32'd0);
    chk("reset_in_ready", 32'(if2.in_ready), 32'd1);
    chk("reset_sig_enable", 32'(en2), 32'd1);
    q2.delete();
    repeat (2) @(posedge clk);
    #1;
    if2.out_ready = 1'b1;
    resetn2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("stale_valid", 32'(if2.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send2(vecs[8]);

    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 50) begin @(posedge clk); #1; n++; end
    if (q0.size() != 0 || q2.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d/%0d results outstanding, required 0/0", q0.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/recip_round_pack.md
# recip_round_pack

Front-end/back-end wrapper around the SRT reciprocal significand engine `recip_sigcalc`. It accepts a packed IEEE-754 operand with a valid/ready handshake and presents the significand `d` to `recip_sigcalc`. It carries sign, exponent and special-case class through a side-band delay line matched to the engine's pipeline depth. It then rounds (RNE), computes the result exponent, handles specials and flush-to-zero, and registers the packed reciprocal behind an output valid/ready handshake.

## Interface
Parameters:
- `sig_width`, 23: fraction bits.
- `exp_width`, 8: exponent bits.
- `pipe_stages`, 0: register stages inside the attached `recip_sigcalc` (0–3); must match the instance.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset; asynchronous, active-low; one clock domain.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`.
- `x_in`  in  `sig_width+exp_width+1`  packed operand {sign, exp, frac}.
- `d_out`  out  `sig_width+1`  {1'b1, frac} to engine `d`.
- `sig_enable`  out  1  to engine `enable`.
- `quotient`  in  `sig_width+1`  engine quotient, hidden bit at MSB.
- `guard_bit`, `round_bit`, `sticky_bit`  in  1 each  engine rounding bits.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `z_out`  out  `sig_width+exp_width+1`  packed reciprocal.
- `status`  out  4  {invalid, div_by_zero, underflow, inexact} (see Configuration).

## Operation
- `advance = ~out_valid | out_ready`. Drive `in_ready`, `sig_enable` and every delay-line and output-register update from `advance`.
- Classify `x_in`: ZERO (exp 0; subnormals treated as zero, DAZ), NORMAL, INF, QNAN, SNAN.
- Delay line: `pipe_stages` entries of {valid, sign, exp, frac_is_zero, class}. Shift only when `advance`. With `pipe_stages==0` the path is combinational into the round stage.
- Round/pack for NORMAL:
  - `frac!=0`: `e_pre = 2*BIAS-1-exp`, mantissa = `quotient[sig_width-1:0]`. RNE increment when `g & (r | s | lsb)`. Mantissa carry-out gives mantissa 0 and `e_pre+1`.
  - `frac==0`: `e_pre = 2*BIAS-exp`, mantissa 0, exact; engine bits are ignored.
  - `e_pre <= 0`: output ±0 with underflow and inexact set. No subnormal outputs. Overflow cannot occur.
  - `inexact = g|r|s` (when not flushed).
- Specials:
  - ±ZERO gives ±inf with div_by_zero.
  - ±INF gives ±0.
  - QNAN gives canonical qNaN `0x7FC00000`-style (sign 0, frac MSB set).
  - SNAN gives canonical qNaN with invalid.
- Output register loads {z, status, valid} when `advance`. A bubble loads valid 0.

## Timing
- Latency: `pipe_stages+1` cycles from accepted input to `out_valid`. Throughput is 1/cycle while `out_ready=1`.
- Stall: `out_valid & ~out_ready` freezes the engine, delay line and output register. `z_out` and `status` stay stable and no entry is lost or duplicated.
- `in_ready` depends combinationally on `out_ready`. This is accepted.
- Reset (async assert): all delay-line valids, `out_valid`, `z_out` and `status` go to 0. `in_ready` and `sig_enable` read 1 during reset. In-flight operations are discarded.

## Configuration
- `RECIP_FLAGS_EN`:
  - Defined: `status` is computed and registered as above.
  - Undefined: `status` is tied to 4'b0000 and its flag logic and registers are removed. Data results are identical.

## Structure
- Package `recip_pkg` holds:
  - the class enum {ZERO, NORMAL, INF, QNAN, SNAN};
  - status bit index constants;
  - `BIAS` as a function of `exp_width`;
  - the delay-line entry struct.
- Sub-module `recip_classify`: combinational classifier for `x_in`. The top module instantiates `recip_classify`; the delay line and round stage stay inline.

## Test plan
All scenarios use single precision. Cycle counts assume `pipe_stages=0` unless noted.
- `x_in=0x40000000` -> `z_out=0x3F000000`, status 0, 1 cycle.
- `x_in=0x3FC00000` -> `0x3F2AAAAB`, inexact only.
- `x_in=0x80000000` -> `0xFF800000`, div_by_zero only.
- `x_in=0x7F800001` -> `0x7FC00000`, invalid. `x_in=0x7F800000` -> `0x00000000`, status 0.
- `x_in=0x7F7FFFFF` -> `0x00000000`, underflow and inexact.
- With `pipe_stages=2`: 3 back-to-back inputs, `out_ready` held low 4 cycles -> `sig_enable=0` during the stall, results emerge in order with none lost. Then `resetn` pulsed mid-stream -> `out_valid=0` immediately and no stale result after release.
